alu_seq: RTL and testbench

Multi-cycle, handshaked ALU responder: the datapath end of the `i_a`/`i_b`/`i_cmd` → `o_result`/`o_valid`/`o_ready` command interface that the ALU benches drive. It accepts one command at a time when idle and executes single-cycle logic/add/sub operations or a 32-cycle iterative multiply. It returns the result with a one-cycle valid pulse, then re-raises ready. It sits directly under the stimulus/initiator, alongside `sim` for clock and reset.

---
 rtl/alu_seq_pkg.sv | 21 ++
 rtl/alu_mul_iter.sv | 80 ++++++++
 rtl/alu_seq.sv | 120 ++++++++++++
 tb/tb_alu_seq.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcode and FSM state encodings shared by alu_seq and its benches
package alu_seq_pkg;

  // Command opcodes; anything above OP_XOR is illegal and completes with result 0.
  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;

  // Sequencer states. RST is held while reset is asserted and left on the first edge after.
  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_IDLE = 2'd1,
    ST_EXEC = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - start/done shift-add multiplier, one bit of B per cycle
module alu_mul_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(MUL_CYCLES - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] acc_step;

  // One shift-add iteration; on the last iteration this is already the final product,
  // so the sequencer can capture it on the same edge the counter wraps.
  always_comb begin
    acc_step = acc_q + (b_sh_q[0] ? a_sh_q : '0);
  end

  // Load operands on start, then iterate until the counter reaches its last value.
  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    busy_d = busy_q;
    done   = 1'b0;
    if (start) begin
      cnt_d  = '0;
      acc_d  = '0;
      a_sh_d = i_a;
      b_sh_d = i_b;
      busy_d = 1'b1;
    end else if (busy_q) begin
      acc_d  = acc_step;
      a_sh_d = a_sh_q << 1;
      b_sh_d = b_sh_q >> 1;
      if (cnt_q == LAST_CNT) begin
        done   = 1'b1;
        cnt_d  = '0;
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign product = acc_step;

  // Multiplier state registers; reset aborts any iteration in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      a_sh_q <= '0;
      b_sh_q <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked multi-cycle ALU: FSM, operand latches, datapath, result register
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_cmd,
  output logic [WIDTH-1:0] o_result,
  output logic             o_valid,
  output logic             o_ready
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       cmd_q, cmd_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] alu_out;

  // NOP while idle is not an accept, so the block simply stays ready.
  assign accept    = (state_q == ST_IDLE) && (i_cmd != OP_NOP);
  assign mul_start = accept && (i_cmd == OP_MUL);

  alu_mul_iter #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .i_a     (i_a),
    .i_b     (i_b),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle datapath on the latched operands; illegal codes yield zero.
  always_comb begin
    alu_out = '0;
    case (cmd_q)
      OP_ADD:  alu_out = a_q + b_q;
      OP_SUB:  alu_out = a_q - b_q;
      OP_AND:  alu_out = a_q & b_q;
      OP_OR:   alu_out = a_q | b_q;
      OP_XOR:  alu_out = a_q ^ b_q;
      default: alu_out = '0;
    endcase
  end

  // Next-state logic: latch the command on accept, capture the result leaving EXEC.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cmd_d    = cmd_q;
    result_d = result_q;
    case (state_q)
      ST_RST: begin
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (accept) begin
          a_d     = i_a;
          b_d     = i_b;
          cmd_d   = i_cmd;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cmd_q == OP_MUL) begin
          if (mul_done) begin
            result_d = mul_product;
            state_d  = ST_DONE;
          end
        end else begin
          result_d = alu_out;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_RST;
      end
    endcase
  end

  // State and datapath registers; asynchronous reset returns every output to its reset value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_RST;
      a_q      <= '0;
      b_q      <= '0;
      cmd_q    <= OP_NOP;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cmd_q    <= cmd_d;
      result_q <= result_d;
    end
  end

  assign o_ready  = (state_q == ST_IDLE);
  assign o_valid  = (state_q == ST_DONE);
  assign o_result = result_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed scoreboard bench for alu_seq
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic [3:0]  i_cmd;
  logic [31:0] o_result;
  logic        o_valid;
  logic        o_ready;

  int          n_vec;
  int          n_err;
  logic [31:0] exp_q[$];

  alu_seq #(.WIDTH(32), .MUL_CYCLES(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_cmd    (i_cmd),
    .o_result (o_result),
    .o_valid  (o_valid),
    .o_ready  (o_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] c);
    logic [31:0] r;
    case (c)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_MUL:  r = a * b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: every valid pulse must match the oldest outstanding command.
  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      chk("spurious_valid", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk("result", o_result, exp_q.pop_front());
      chk("ready_during_valid", 32'(o_ready), 32'd0);
    end
  end

  // Issue one command on the first ready edge and check its handshake timing.
  task automatic run_cmd(input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] c, input bit scramble);
    int waitc;
    int elapsed;
    int exp_lat;
    waitc = 0;
    while (o_ready !== 1'b1 && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    chk("ready_wait", 32'(o_ready), 32'd1);
    i_a = a;
    i_b = b;
    i_cmd = c;
    exp_q.push_back(model(a, b, c));
    exp_lat = (c == OP_MUL) ? 32 : 1;
    @(negedge clk);
    chk("ready_fall", 32'(o_ready), 32'd0);
    if (!scramble) i_cmd = OP_NOP;
    elapsed = 0;
    while (o_valid !== 1'b1 && elapsed < 100) begin
      if (scramble) begin
        i_a = $urandom;
        i_b = $urandom;
        i_cmd = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      elapsed++;
    end
    i_cmd = OP_NOP;
    chk("valid_latency", 32'(elapsed), 32'(exp_lat));
    @(negedge clk);
    chk("ready_rise", 32'(o_ready), 32'd1);
    chk("valid_fall", 32'(o_valid), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    i_a = 32'd0;
    i_b = 32'd0;
    i_cmd = OP_NOP;

    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", 32'(o_ready), 32'd0);
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_result", o_result, 32'd0);
    end
    reset = 1'b1;
    #1;
    chk("release_ready_low", 32'(o_ready), 32'd0);
    @(negedge clk);
    chk("release_ready_high", 32'(o_ready), 32'd1);
    chk("release_valid", 32'(o_valid), 32'd0);
    chk("release_result", o_result, 32'd0);

    run_cmd(32'hFFFF_FFFF, 32'd2, OP_ADD, 1'b0);
    chk("add_wrap", o_result, 32'h0000_0001);
    run_cmd(32'd0, 32'd1, OP_SUB, 1'b0);
    chk("sub_borrow", o_result, 32'hFFFF_FFFF);
    run_cmd(32'h1234_5678, 32'h0F0F_0F0F, 4'hF, 1'b0);
    chk("illegal_zero", o_result, 32'd0);

    i_cmd = OP_NOP;
    repeat (5) begin
      @(negedge clk);
      chk("nop_ready", 32'(o_ready), 32'd1);
      chk("nop_valid", 32'(o_valid), 32'd0);
    end

    run_cmd(32'h0001_0003, 32'h0002_0005, OP_MUL, 1'b0);
    chk("mul_small", o_result, 32'h000B_000F);
    run_cmd(32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_MUL, 1'b0);
    chk("mul_max", o_result, 32'h0000_0001);
    run_cmd(32'h1234_5678, 32'h9ABC_DEF1, OP_MUL, 1'b1);

    for (int k = 0; k < 6; k++) begin
      run_cmd($urandom, $urandom, 4'($urandom_range(1, 15)), 1'b0);
    end
    run_cmd(32'hA5A5_0000, 32'h0000_5A5A, OP_OR, 1'b0);
    run_cmd(32'hFF00_FF00, 32'h0FF0_0FF0, OP_XOR, 1'b0);
    run_cmd(32'hFF00_FF00, 32'h0FF0_0FF0, OP_AND, 1'b0);
    run_cmd(32'd5, 32'd6, OP_ADD, 1'b0);

    i_a = 32'hDEAD_BEEF;
    i_b = 32'h0000_0077;
    i_cmd = OP_MUL;
    @(negedge clk);
    chk("abort_accept", 32'(o_ready), 32'd0);
    i_cmd = OP_NOP;
    repeat (10) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_ready", 32'(o_ready), 32'd0);
    chk("abort_valid", 32'(o_valid), 32'd0);
    chk("abort_result", o_result, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_hold_valid", 32'(o_valid), 32'd0);
      chk("abort_hold_ready", 32'(o_ready), 32'd0);
    end
    reset = 1'b1;
    #1;
    chk("rerelease_ready_low", 32'(o_ready), 32'd0);
    @(negedge clk);
    chk("rerelease_ready_high", 32'(o_ready), 32'd1);
    run_cmd(32'd3, 32'd4, OP_ADD, 1'b0);
    chk("post_abort_add", o_result, 32'd7);

    repeat (40) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
